quartsine_phase_ctrl: RTL

//   Sequencer for the quarter-wave sine datapath. Accumulates a tuning word into a phase, splits it into quadrant + index,
//   and drives the quarter-table address, mirror (phasesw) and invert controls. All outputs are aligned to the LUT read

---
 rtl/quartsine_pkg.sv | 40 ++++
 rtl/quartsine_phase_ctrl_if.sv | 27 ++
 rtl/pb_debounce.sv | 38 +++
 rtl/quartsine_phase_ctrl.sv | 122 ++++++++++++
 4 files changed

// File: rtl/quartsine_pkg.sv
// Shared types and helpers for the quarter-wave sine phase sequencer.
// Holds the quadrant encoding, the default widths and the mirror/invert decode.
package quartsine_pkg;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_TW_W   = 8;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quadrant_e;

  typedef struct packed {
    logic mirror;
    logic invert;
  } quad_ctrl_t;

  typedef struct packed {
    logic valid;
    logic phasesw;
    logic invert;
  } samp_ctl_t;

  // Q1/Q3 walk the table backwards, Q2/Q3 are the negative half-wave
  function automatic quad_ctrl_t quad_decode(input quadrant_e q);
    quad_ctrl_t c;
    c = '0;
    case (q)
      Q0: c = '{mirror: 1'b0, invert: 1'b0};
      Q1: c = '{mirror: 1'b1, invert: 1'b0};
      Q2: c = '{mirror: 1'b0, invert: 1'b1};
      Q3: c = '{mirror: 1'b1, invert: 1'b1};
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/quartsine_phase_ctrl_if.sv
// Signal bundle between the SW/button front end, the quarter-sine LUT and PWM stage.
// master = stimulus/consumer side, slave = the phase controller.
interface quartsine_phase_ctrl_if #(
  parameter int unsigned ADDR_W = quartsine_pkg::DEF_ADDR_W,
  parameter int unsigned TW_W   = quartsine_pkg::DEF_TW_W
);

  logic [TW_W-1:0]   sw;
  logic              btn;
  logic [ADDR_W-1:0] lut_addr;
  logic              phasesw;
  logic              invert;
  logic              sample_valid;
  logic              amp_en;
  logic [1:0]        quadrant;

  modport master (
    output sw, btn,
    input  lut_addr, phasesw, invert, sample_valid, amp_en, quadrant
  );

  modport slave (
    input  sw, btn,
    output lut_addr, phasesw, invert, sample_valid, amp_en, quadrant
  );

endinterface

// File: rtl/pb_debounce.sv
// Push-button debouncer: 2-FF synchroniser, then the level only follows the input
// once it has disagreed with the current level for DB_CYCLES consecutive clocks.
module pb_debounce #(
  parameter int unsigned DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], btn_raw};
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign btn_level = r_level;

endmodule

// File: rtl/quartsine_phase_ctrl.sv
// Phase sequencer for the quarter-wave sine datapath: sample divider, phase accumulator
// with zero-crossing tuning latch, quadrant decode, LUT-latency pipe and run/mute toggle.
module quartsine_phase_ctrl import quartsine_pkg::*; #(
  parameter int unsigned ACC_W      = 24,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned TW_W       = DEF_TW_W,
  parameter int unsigned SAMPLE_DIV = 1134,
  parameter int unsigned LUT_LAT    = 1,
  parameter int unsigned DB_CYCLES  = 500000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  quartsine_phase_ctrl_if.slave bus
);

  localparam int unsigned DIV_W = $clog2(SAMPLE_DIV);

  logic [DIV_W-1:0]  r_div;
  logic [ACC_W-1:0]  r_acc;
  logic [TW_W-1:0]   r_tw;
  logic              r_run;
  logic              r_btn_q;
  logic [ADDR_W-1:0] r_addr;
  quadrant_e         r_quad;
  samp_ctl_t         r_st0;
  samp_ctl_t         r_pipe [LUT_LAT];

  logic              w_btn_level;
  logic              w_press;
  logic              w_run_next;
  logic              w_tick;
  logic              w_adv;
  logic              w_carry;
  logic [ACC_W-1:0]  w_acc_sum;
  quadrant_e         w_quad;
  logic [ADDR_W-1:0] w_idx;
  logic [ADDR_W-1:0] w_addr;
  quad_ctrl_t        w_ctrl;

  pb_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (bus.btn),
    .btn_level(w_btn_level)
  );

  assign w_press    = w_btn_level & ~r_btn_q;
  assign w_run_next = r_run ^ w_press;
  assign w_tick     = (r_div == DIV_W'(SAMPLE_DIV - 1));
  // A tick coinciding with the run-off toggle is dropped
  assign w_adv      = w_tick & r_run & w_run_next;

  assign {w_carry, w_acc_sum} = {1'b0, r_acc} + (ACC_W + 1)'(r_tw);

  assign w_quad = quadrant_e'(w_acc_sum[ACC_W-1 -: 2]);
  assign w_idx  = w_acc_sum[ACC_W-3 -: ADDR_W];
  assign w_ctrl = quad_decode(w_quad);
  assign w_addr = w_ctrl.mirror ? ~w_idx : w_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div   <= '0;
      r_run   <= 1'b1;
      r_btn_q <= 1'b0;
    end else begin
      r_div   <= w_tick ? '0 : r_div + 1'b1;
      r_run   <= w_run_next;
      r_btn_q <= w_btn_level;
    end
  end

  // Tuning word only changes at an accumulator wrap, keeping the output phase-continuous
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_tw  <= '0;
    end else begin
      if (!w_run_next) begin
        r_acc <= '0;
      end else if (w_adv) begin
        r_acc <= w_acc_sum;
      end
      if (!r_run || (w_adv && w_carry)) begin
        r_tw <= bus.sw;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_quad <= Q0;
      r_st0  <= '0;
      for (int unsigned i = 0; i < LUT_LAT; i++) r_pipe[i] <= '0;
    end else if (!w_run_next) begin
      r_addr <= '0;
      r_quad <= Q0;
      r_st0  <= '0;
      for (int unsigned i = 0; i < LUT_LAT; i++) r_pipe[i] <= '0;
    end else begin
      if (w_adv) begin
        r_addr <= w_addr;
        r_quad <= w_quad;
        r_st0  <= '{valid: 1'b1, phasesw: w_ctrl.mirror, invert: w_ctrl.invert};
      end else begin
        r_st0.valid <= 1'b0;
      end
      r_pipe[0] <= r_st0;
      for (int unsigned i = 1; i < LUT_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign bus.lut_addr     = r_addr;
  assign bus.quadrant     = r_quad;
  assign bus.sample_valid = r_pipe[LUT_LAT-1].valid;
  assign bus.phasesw      = r_pipe[LUT_LAT-1].phasesw;
  assign bus.invert       = r_pipe[LUT_LAT-1].invert;
  assign bus.amp_en       = r_run;

endmodule
